ex_mem_stage: RTL
=================

# ex_mem_stage

Execute/memory stage of the 4-stage pipeline (IF, ID, EX/MEM, WB). Consumes the ID/EX pipeline register outputs and performs the ALU operation and the data-memory access. It keeps the N/Z condition flags and resolves branches and jumps, then registers results into the EX/WB register feeding write-back. Memory operations use a ready handshake and stall upstream. Taken control transfers redirect fetch and squash younger instructions.

## Interface
- `KILL_SLOTS`, default 2: younger valid instructions squashed after a redirect.
- `clk  in  1`: single clock; all state updates on the falling edge (pipeline-register convention).
- `rst_n  in  1`: asynchronous, active-low reset.
- `id_valid  in  1`: ID/EX holds a real instruction.
- `RegWrt, MemtoReg, PCtoReg, BranchN, BranchZ, Jump, JumpMem, memRead, memWrite  in  1 each`: control from ID/EX.
- `ALUop  in  2`: operation select.
- `Xrs, Xrt  in  32`: register operands.
- `Y  in  32`: sign-extended immediate.
- `PC_Y  in  32`: precomputed PC+Y.
- `rd  in  6`: destination register index.
- `ex_stall  out  1`: hold IF/ID and ID/EX.
- `dmem_addr, dmem_wdata  out  32`: data-memory address and write data.
- `dmem_re, dmem_we  out  1`: data-memory read and write requests.
- `dmem_rdata  in  32`, `dmem_ready  in  1`: memory response.
- `redirect_valid  out  1`, `redirect_pc  out  32`: fetch redirect.
- `wb_valid, wb_RegWrt  out  1`, `wb_rd  out  6`, `wb_data  out  32`: EX/WB register.

## Operation
- An instruction is **live** when `id_valid` is 1 and `kill_cnt` is 0. A valid instruction arriving while `kill_cnt` > 0 is a bubble:
  - no writeback, flag update, memory access or redirect;
  - `kill_cnt` decrements.
- ALU, 32-bit with wrap and no overflow:
  - `00`: Xrs+Xrt
  - `01`: Xrs+Y
  - `10`: 0−Xrs
  - `11`: Xrs−Xrt
- Flags N and Z are registered. They update only on retirement of a live instruction with RegWrt=1, MemtoReg=0, PCtoReg=0: N=res[31], Z=(res==0).
- Branch decisions use the flag values before the current instruction's own update:
  - BranchZ is taken if Z=1.
  - BranchN is taken if N=1.
  - Jump is always taken.
  - Target = Xrs.
  - JumpMem target = mem[Xrs].
- Memory ops are memRead, memWrite and JumpMem: `dmem_addr`=Xrs, and for writes `dmem_wdata`=Xrt.
- `wb_data` select: PCtoReg → PC_Y; MemtoReg → captured rdata; otherwise ALU result.
- FSM:
  - **RUN**:
    - A live non-memory instruction retires on the current edge.
    - A live memory op registers addr/wdata, asserts re/we and goes to **MEM**.
  - **MEM**:
    - Hold the request stable.
    - On an edge with `dmem_ready`=1: capture rdata, drop re/we, retire, return to RUN.
- `ex_stall` = (RUN & live memory op) | MEM. It is forced to 0 while `rst_n`=0.
- On a taken branch/jump/JumpMem at retirement:
  - `redirect_valid`=1 for exactly one cycle, with `redirect_pc` = target.
  - `kill_cnt` loads KILL_SLOTS.

## Timing
- ALU and control-transfer instructions: 1 cycle. `wb_*` and `redirect_*` are valid after the falling edge that consumes the instruction.
- Memory ops: at least 2 cycles. Retirement occurs on the first edge in MEM with `dmem_ready`=1. `ex_stall` stays high through that edge.
- `wb_valid` pulses one cycle per retired live instruction. `wb_RegWrt` = RegWrt gated by `wb_valid`.
- `kill_cnt` decrements only on non-stalled edges with `id_valid`=1. A redirect never occurs while `kill_cnt` > 0.
- Reset (asynchronous, immediate, including mid-MEM): state RUN; N=Z=0; `kill_cnt`=0; all outputs 0; the outstanding memory request is abandoned.
- `dmem_ready` in RUN is ignored.
- Simultaneous memRead and memWrite is illegal; memWrite takes priority.

## Structure
- Package `ex_pkg`: ALUop encodings, FSM state encoding (RUN, MEM), KILL_SLOTS default.
- Sub-module `ex_alu`: combinational, takes ALUop, Xrs, Xrt, Y and produces result, n and z.
- The top level holds the FSM, flags, kill counter and EX/WB register.

## Test plan
- ALUop=11, Xrs=5, Xrt=7, RegWrt=1, rd=3 → after one edge: wb_data=0xFFFFFFFE, wb_rd=3, wb_valid=1, N=1, Z=0.
- Previous result 0 (Z=1), then BranchZ with Xrs=0x40 → redirect_valid pulse with redirect_pc=0x40. The next 2 valid instructions (ADD with RegWrt) produce no wb_valid and no flag change.
- memRead with Xrs=0x10 and `dmem_ready` held low 3 cycles → ex_stall high 4 cycles. On ready, rdata=0xDEADBEEF: wb_data=0xDEADBEEF, MemtoReg path, flags unchanged.
- JumpMem with Xrs=0x20 and mem[0x20]=0x100 → single redirect to 0x100 on the ready edge; no writeback.
- `rst_n` pulled low while in MEM → dmem_re=0, ex_stall=0 and wb_valid=0 immediately. After release, an ADD 1+1 retires with wb_data=2.
- PCtoReg with PC_Y=0x1234 → wb_data=0x1234, flags unchanged.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared types for the EX/MEM stage.
// ALU op codes, FSM states, kill-counter sizing, pending-op bundle.
package ex_pkg;

   localparam int KILL_SLOTS_DEF = 2;
   localparam int KW = 4;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'b00,
      ALU_ADDI = 2'b01,
      ALU_NEG  = 2'b10,
      ALU_SUB  = 2'b11
   } alu_op_e;

   typedef enum logic {
      ST_RUN = 1'b0,
      ST_MEM = 1'b1
   } ex_state_e;

   // Everything needed to retire an instruction, latched while in MEM.
   typedef struct packed {
      logic [5:0]  rd;
      logic        regwrt;
      logic        memtoreg;
      logic        pctoreg;
      logic        flagupd;
      logic        jumpmem;
      logic        taken;
      logic [31:0] pc_y;
      logic [31:0] res;
      logic [31:0] target;
   } ex_pend_t;

endpackage

// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if: ID/EX inputs, data-memory port, redirect and EX/WB outputs.
// slave = the stage itself, master = upstream/memory/write-back side.
interface ex_mem_stage_if;

   logic        id_valid;
   logic        RegWrt, MemtoReg, PCtoReg;
   logic        BranchN, BranchZ, Jump, JumpMem;
   logic        memRead, memWrite;
   logic [1:0]  ALUop;
   logic [31:0] Xrs, Xrt, Y, PC_Y;
   logic [5:0]  rd;
   logic        ex_stall;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_re, dmem_we;
   logic [31:0] dmem_rdata;
   logic        dmem_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        wb_valid, wb_RegWrt;
   logic [5:0]  wb_rd;
   logic [31:0] wb_data;

   modport slave (
      input  id_valid, RegWrt, MemtoReg, PCtoReg,
      input  BranchN, BranchZ, Jump, JumpMem,
      input  memRead, memWrite, ALUop,
      input  Xrs, Xrt, Y, PC_Y, rd,
      input  dmem_rdata, dmem_ready,
      output ex_stall, dmem_addr, dmem_wdata,
      output dmem_re, dmem_we,
      output redirect_valid, redirect_pc,
      output wb_valid, wb_RegWrt, wb_rd, wb_data
   );

   modport master (
      output id_valid, RegWrt, MemtoReg, PCtoReg,
      output BranchN, BranchZ, Jump, JumpMem,
      output memRead, memWrite, ALUop,
      output Xrs, Xrt, Y, PC_Y, rd,
      output dmem_rdata, dmem_ready,
      input  ex_stall, dmem_addr, dmem_wdata,
      input  dmem_re, dmem_we,
      input  redirect_valid, redirect_pc,
      input  wb_valid, wb_RegWrt, wb_rd, wb_data
   );

endinterface

// File: rtl/ex_alu.sv
// ex_alu: 32-bit combinational ALU (wrapping, no overflow).
// in: i_op, i_xrs, i_xrt, i_y  out: o_res, o_n, o_z
module ex_alu
   import ex_pkg::*;
(
   input  alu_op_e     i_op,
   input  logic [31:0] i_xrs,
   input  logic [31:0] i_xrt,
   input  logic [31:0] i_y,
   output logic [31:0] o_res,
   output logic        o_n,
   output logic        o_z
);

   logic [31:0] w_res;

   always_comb begin
      w_res = '0;
      unique case (i_op)
         ALU_ADD:  w_res = i_xrs + i_xrt;
         ALU_ADDI: w_res = i_xrs + i_y;
         ALU_NEG:  w_res = 32'd0 - i_xrs;
         ALU_SUB:  w_res = i_xrs - i_xrt;
      endcase
   end

   assign o_res = w_res;
   assign o_n   = w_res[31];
   assign o_z   = (w_res == '0);

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM stage - ALU, N/Z flags, branch resolve, memory FSM, EX/WB reg.
// ports: clk, rst_n (async, active-low), bus (ex_mem_stage_if.slave). State on falling edge.
module ex_mem_stage
   import ex_pkg::*;
#(
   parameter int KILL_SLOTS = KILL_SLOTS_DEF
)(
   input logic           clk,
   input logic           rst_n,
   ex_mem_stage_if.slave bus
);

   ex_state_e   r_state;
   ex_pend_t    r_pend;
   logic [KW-1:0] r_kill;
   logic        r_n, r_z;
   logic [31:0] r_addr, r_wdata;
   logic        r_re, r_we;
   logic        r_redir;
   logic [31:0] r_redir_pc;
   logic        r_wb_valid, r_wb_regwrt;
   logic [5:0]  r_wb_rd;
   logic [31:0] r_wb_data;

   logic [31:0] w_res;
   logic        w_n, w_z;
   logic        w_live, w_memop, w_do_ret;
   ex_pend_t    w_pend, w_ret;
   logic [31:0] w_wbd;

   ex_alu u_alu (
      .i_op  (alu_op_e'(bus.ALUop)),
      .i_xrs (bus.Xrs),
      .i_xrt (bus.Xrt),
      .i_y   (bus.Y),
      .o_res (w_res),
      .o_n   (w_n),
      .o_z   (w_z)
   );

   assign w_live  = bus.id_valid && (r_kill == '0);
   assign w_memop = bus.memRead | bus.memWrite | bus.JumpMem;

   // Branch decision uses the flags as they stand before this instruction.
   always_comb begin
      w_pend          = '0;
      w_pend.rd       = bus.rd;
      w_pend.regwrt   = bus.RegWrt;
      w_pend.memtoreg = bus.MemtoReg;
      w_pend.pctoreg  = bus.PCtoReg;
      w_pend.flagupd  = bus.RegWrt & ~bus.MemtoReg & ~bus.PCtoReg;
      w_pend.jumpmem  = bus.JumpMem;
      w_pend.taken    = bus.Jump | bus.JumpMem
                      | (bus.BranchZ & r_z)
                      | (bus.BranchN & r_n);
      w_pend.pc_y     = bus.PC_Y;
      w_pend.res      = w_res;
      w_pend.target   = bus.Xrs;
   end

   assign w_ret = (r_state == ST_MEM) ? r_pend : w_pend;

   assign w_do_ret = ((r_state == ST_RUN) && w_live && !w_memop)
                   || ((r_state == ST_MEM) && bus.dmem_ready);

   always_comb begin
      w_wbd = w_ret.res;
      if (w_ret.pctoreg)
         w_wbd = w_ret.pc_y;
      else if (w_ret.memtoreg)
         w_wbd = bus.dmem_rdata;
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_RUN;
         r_pend      <= '0;
         r_kill      <= '0;
         r_n         <= 1'b0;
         r_z         <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_re        <= 1'b0;
         r_we        <= 1'b0;
         r_redir     <= 1'b0;
         r_redir_pc  <= '0;
         r_wb_valid  <= 1'b0;
         r_wb_regwrt <= 1'b0;
         r_wb_rd     <= '0;
         r_wb_data   <= '0;
      end else begin
         r_wb_valid  <= 1'b0;
         r_wb_regwrt <= 1'b0;
         r_redir     <= 1'b0;
         unique case (r_state)
            ST_RUN: begin
               if (bus.id_valid && (r_kill != '0)) begin
                  r_kill <= r_kill - KW'(1);
               end else if (w_live && w_memop) begin
                  r_state <= ST_MEM;
                  r_pend  <= w_pend;
                  r_addr  <= bus.Xrs;
                  r_wdata <= bus.memWrite ? bus.Xrt : '0;
                  r_we    <= bus.memWrite;
                  r_re    <= ~bus.memWrite;
               end
            end
            ST_MEM: begin
               if (bus.dmem_ready) begin
                  r_state <= ST_RUN;
                  r_re    <= 1'b0;
                  r_we    <= 1'b0;
               end
            end
         endcase
         if (w_do_ret) begin
            r_wb_valid  <= 1'b1;
            r_wb_regwrt <= w_ret.regwrt;
            r_wb_rd     <= w_ret.rd;
            r_wb_data   <= w_wbd;
            if (w_ret.flagupd) begin
               r_n <= w_ret.res[31];
               r_z <= (w_ret.res == '0);
            end
            if (w_ret.taken) begin
               r_redir    <= 1'b1;
               r_redir_pc <= w_ret.jumpmem ? bus.dmem_rdata
                                           : w_ret.target;
               r_kill     <= KW'(KILL_SLOTS);
            end
         end
      end
   end

   // Combinational so upstream holds on the very cycle a memory op shows up.
   assign bus.ex_stall = rst_n
                       & (((r_state == ST_RUN) & w_live & w_memop)
                       | (r_state == ST_MEM));

   assign bus.dmem_addr      = r_addr;
   assign bus.dmem_wdata     = r_wdata;
   assign bus.dmem_re        = r_re;
   assign bus.dmem_we        = r_we;
   assign bus.redirect_valid = r_redir;
   assign bus.redirect_pc    = r_redir_pc;
   assign bus.wb_valid       = r_wb_valid;
   assign bus.wb_RegWrt      = r_wb_regwrt;
   assign bus.wb_rd          = r_wb_rd;
   assign bus.wb_data        = r_wb_data;

endmodule
